axi_burst_splitter: RTL and testbench
=====================================

# axi_burst_splitter

Converts arbitrary AXI4 bursts from the TaPaSCo slave pin adapter into single-beat AXI4 transactions for the CLINT timer slave, which only supports `len == 0` accesses. Sits between the raw AXI slave pin connection and `clint` inside the timer top level. It regenerates per-beat addresses for FIXED, INCR and WRAP bursts, merges write responses, and rebuilds `rlast` upstream. Atomic (ATOP) and reserved-burst requests are answered locally with SLVERR.

## Interface
- `AXI_ID_WIDTH`, default 5: ID width carried unchanged; must match `tapasco_axi::IdWidthSlave`.
- `req_t`, default `tapasco_axi::req_slv_t`: AXI4 request struct, 64-bit address and data.
- `resp_t`, default `tapasco_axi::resp_slv_t`: AXI4 response struct.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: asynchronous reset, active-high.
- `slv_req_i`, in, req_t: upstream request, bursts allowed.
- `slv_resp_o`, out, resp_t: upstream response.
- `mst_req_o`, out, req_t: downstream request to `clint`, always `len = 0`.
- `mst_resp_i`, in, resp_t: downstream response from `clint`.

## Operation
- Read and write paths are independent FSMs. Each path has at most one upstream burst outstanding.
- **Write FSM states:** `W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`, `W_BRESP`, `W_DRAIN`.
  - `W_IDLE`: `aw_ready = 1`. On AW handshake, latch id, addr, len, size, burst, prot, cache, qos, region, user. Set the beat counter to `len` and clear the merged response to OKAY.
  - If `atop != 0` or `burst == 2'b11`, go to `W_DRAIN`. Otherwise go to `W_ADDR`.
  - `W_ADDR`: drive downstream AW with the current address, `len = 0` and `burst = INCR`. Go to `W_DATA` on handshake.
  - `W_DATA`: pass one upstream W beat through, forcing downstream `wlast = 1`. Go to `W_RESP` on handshake.
  - `W_RESP`: `b_ready = 1` downstream. Merge the response: worst of accumulated and received, ranked DECERR > SLVERR > OKAY, with EXOKAY counted as OKAY.
    - If the counter is 0, go to `W_BRESP`.
    - Otherwise decrement the counter, advance the address and go to `W_ADDR`.
  - `W_DRAIN`: accept W beats locally until `wlast`, with no downstream traffic. Set the merged response to SLVERR and go to `W_BRESP`.
  - `W_BRESP`: present upstream B with the latched id and merged response. Go to `W_IDLE` on `b_ready`.
- **Read FSM states:** `R_IDLE`, `R_ADDR`, `R_DATA`, `R_ERR`.
  - `R_ADDR`: issue a single-beat AR.
  - `R_DATA`: forward downstream R upstream with the latched id. Set `rlast = 1` only when the counter is 0. Downstream `r_ready` equals upstream `r_ready`.
  - Reserved burst types go to `R_ERR`, which returns `len + 1` beats with `rdata = 0` and SLVERR, asserting `rlast` on the final beat.
- **Address rules:** `step = 1 << size`.
  - FIXED: address constant.
  - INCR: `addr + step`, 64-bit, wraps modulo 2^64.
  - WRAP: `wrap_bytes = (len + 1) * step`, `lower = addr & ~(wrap_bytes - 1)`. When `addr + step == lower + wrap_bytes`, the next address is `lower`.
  - A WRAP with `len` not in {1, 3, 7, 15} is treated as INCR.
- Upstream `w_ready` is 0 in every write state except `W_DATA` (downstream-gated) and `W_DRAIN` (1).

## Timing
- Reset values:
  - All `*_valid` outputs are 0.
  - `aw_ready` and `ar_ready` are 0 during reset and 1 in the first cycle after reset release.
  - `w_ready`, `b_ready` and `r_ready` are 0.
  - Both FSMs are in IDLE, counters are 0, and the merged response is OKAY.
- AW/AR acceptance to downstream address valid: 1 cycle. All address channels are registered.
- The W and R data paths are combinational pass-through (0 added cycles).
- Per write beat: at least 3 cycles (ADDR, DATA, RESP). Upstream B is valid 1 cycle after the last downstream B handshake.
- Valid/ready rule: once valid is asserted, payload is held stable until the handshake.
- The FSMs never drop valid without a handshake, except on reset.
- Simultaneous read and write bursts proceed concurrently with no ordering between them.
- Reset mid-burst returns both FSMs to IDLE immediately. No partial response is emitted.
- `len = 255` with INCR: 256 downstream beats, with the counter never underflowing.

## Structure
- **Shared package `axi_burst_splitter_pkg`:**
  - write and read state enums;
  - burst encodings `BURST_FIXED`, `BURST_INCR`, `BURST_WRAP`;
  - response codes;
  - function `resp_merge(a, b)` implementing the worst-of rule.
- **Sub-module `axi_burst_addr_gen`:** combinational next-address computation from addr, len, size and burst. Instantiated once per path.
- The top level holds the two FSMs, the latched address-channel fields and the beat counters.

## Test plan
- **INCR write:** len=3, size=3, addr 0x0200_4000, four W beats.
  - Downstream AW sequence: 0x4000, 0x4008, 0x4010, 0x4018, each with `len = 0` and `wlast = 1`.
  - One upstream B with OKAY and the original id.
- **WRAP read:** len=3, size=3, addr 0x0200_BFF8.
  - Downstream AR sequence: 0xBFF8, 0xBFE0, 0xBFE8, 0xBFF0.
  - Four upstream R beats, with `rlast` asserted only on the 4th.
- **Error merge:** 4-beat write where `clint` returns SLVERR on beat 2 and OKAY on the others.
  - All 4 beats are still issued.
  - Upstream B is SLVERR.
- **Local rejection:**
  - `atop = 6'h20` write of 2 beats: zero downstream AW; both W beats accepted; B is SLVERR.
  - `burst = 2'b11` read with len=1: two R beats with SLVERR and data 0, `rlast` on the 2nd.
- **Concurrency:** a write burst and a read burst issued in the same cycle both complete with correct ids. Random upstream `b_ready`/`r_ready` backpressure causes no lost or duplicated beats.
- **Reset mid-burst:** assert `rst_i` during beat 2 of a 4-beat write.
  - Next cycle: all valids are 0.
  - After release, a new single-beat write completes normally.

Source files
------------

// File: rtl/axi_burst_splitter_pkg.sv
// Shared types, encodings and helpers for the AXI4 burst splitter.
package axi_burst_splitter_pkg;

    localparam int unsigned ID_WIDTH   = 5;
    localparam int unsigned USER_WIDTH = 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP, W_DRAIN} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [USER_WIDTH-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0]           data;
        logic [7:0]            strb;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [63:0]           data;
        logic [1:0]            resp;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    // Severity rank: DECERR > SLVERR > OKAY, EXOKAY counts as OKAY.
    function automatic logic [1:0] resp_rank(input logic [1:0] r);
        case (r)
            RESP_DECERR: return 2'd2;
            RESP_SLVERR: return 2'd1;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] rk;
        rk = (resp_rank(a) > resp_rank(b)) ? resp_rank(a) : resp_rank(b);
        case (rk)
            2'd2:    return RESP_DECERR;
            2'd1:    return RESP_SLVERR;
            default: return RESP_OKAY;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
    import axi_burst_splitter_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [63:0] next_addr
);

    logic [63:0] step;
    logic [63:0] incr;
    logic [63:0] wrap_bytes;
    logic [63:0] lower;
    logic        wrap_ok;

    // Compute the incremented address and, for legal WRAP lengths, fold it back to the boundary.
    always_comb begin
        step       = 64'd1 << size;
        incr       = addr + step;
        wrap_bytes = ({56'd0, len} + 64'd1) << size;
        lower      = addr & ~(wrap_bytes - 64'd1);
        wrap_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr  = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_ok && (incr == lower + wrap_bytes)) next_addr = lower;
            end
            default: next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits AXI4 bursts into single-beat transactions; read and write paths are independent.
module axi_burst_splitter
    import axi_burst_splitter_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH = 5,
    parameter type         req_t        = axi_req_t,
    parameter type         resp_t       = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    w_state_t                w_state;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [63:0]             w_addr;
    logic [7:0]              w_len;
    logic [7:0]              w_cnt;
    logic [2:0]              w_size;
    logic [1:0]              w_burst;
    logic [2:0]              w_prot;
    logic [3:0]              w_cache;
    logic [3:0]              w_qos;
    logic [3:0]              w_region;
    logic [USER_WIDTH-1:0]   w_user;
    logic [1:0]              w_resp;
    logic [63:0]             w_next_addr;

    r_state_t                r_state;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [63:0]             r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_cnt;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [2:0]              r_prot;
    logic [3:0]              r_cache;
    logic [3:0]              r_qos;
    logic [3:0]              r_region;
    logic [USER_WIDTH-1:0]   r_user;
    logic [63:0]             r_next_addr;

    // Fields the downstream slave has no use for.
    logic unused_fields;
    assign unused_fields = ^{slv_req_i.aw.lock, slv_req_i.ar.lock, mst_resp_i.b.id,
                             mst_resp_i.b.user, mst_resp_i.r.id, mst_resp_i.r.last};

    axi_burst_addr_gen u_w_addr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next_addr)
    );

    axi_burst_addr_gen u_r_addr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .size      (r_size),
        .burst     (r_burst),
        .next_addr (r_next_addr)
    );

    // Write FSM: one downstream AW/W/B round trip per upstream beat, responses merged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_prot   <= '0;
            w_cache  <= '0;
            w_qos    <= '0;
            w_region <= '0;
            w_user   <= '0;
            w_resp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (slv_req_i.aw_valid) begin
                        w_id     <= slv_req_i.aw.id;
                        w_addr   <= slv_req_i.aw.addr;
                        w_len    <= slv_req_i.aw.len;
                        w_cnt    <= slv_req_i.aw.len;
                        w_size   <= slv_req_i.aw.size;
                        w_burst  <= slv_req_i.aw.burst;
                        w_prot   <= slv_req_i.aw.prot;
                        w_cache  <= slv_req_i.aw.cache;
                        w_qos    <= slv_req_i.aw.qos;
                        w_region <= slv_req_i.aw.region;
                        w_user   <= slv_req_i.aw.user;
                        w_resp   <= RESP_OKAY;
                        if ((slv_req_i.aw.atop != 6'd0) || (slv_req_i.aw.burst == BURST_RSVD))
                            w_state <= W_DRAIN;
                        else
                            w_state <= W_ADDR;
                    end
                end
                W_ADDR: if (mst_resp_i.aw_ready) w_state <= W_DATA;
                W_DATA: if (slv_req_i.w_valid && mst_resp_i.w_ready) w_state <= W_RESP;
                W_RESP: begin
                    if (mst_resp_i.b_valid) begin
                        w_resp <= resp_merge(w_resp, mst_resp_i.b.resp);
                        if (w_cnt == 8'd0) begin
                            w_state <= W_BRESP;
                        end else begin
                            w_cnt   <= w_cnt - 8'd1;
                            w_addr  <= w_next_addr;
                            w_state <= W_ADDR;
                        end
                    end
                end
                W_DRAIN: begin
                    if (slv_req_i.w_valid && slv_req_i.w.last) begin
                        w_resp  <= RESP_SLVERR;
                        w_state <= W_BRESP;
                    end
                end
                W_BRESP: if (slv_req_i.b_ready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one downstream AR/R per beat; reserved bursts are answered locally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_prot   <= '0;
            r_cache  <= '0;
            r_qos    <= '0;
            r_region <= '0;
            r_user   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (slv_req_i.ar_valid) begin
                        r_id     <= slv_req_i.ar.id;
                        r_addr   <= slv_req_i.ar.addr;
                        r_len    <= slv_req_i.ar.len;
                        r_cnt    <= slv_req_i.ar.len;
                        r_size   <= slv_req_i.ar.size;
                        r_burst  <= slv_req_i.ar.burst;
                        r_prot   <= slv_req_i.ar.prot;
                        r_cache  <= slv_req_i.ar.cache;
                        r_qos    <= slv_req_i.ar.qos;
                        r_region <= slv_req_i.ar.region;
                        r_user   <= slv_req_i.ar.user;
                        r_state  <= (slv_req_i.ar.burst == BURST_RSVD) ? R_ERR : R_ADDR;
                    end
                end
                R_ADDR: if (mst_resp_i.ar_ready) r_state <= R_DATA;
                R_DATA: begin
                    if (mst_resp_i.r_valid && slv_req_i.r_ready) begin
                        if (r_cnt == 8'd0) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_addr  <= r_next_addr;
                            r_state <= R_ADDR;
                        end
                    end
                end
                R_ERR: begin
                    if (slv_req_i.r_ready) begin
                        if (r_cnt == 8'd0) r_state <= R_IDLE;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Channel outputs decoded from the FSM state; W and R payloads pass straight through.
    always_comb begin
        slv_resp_o = '0;
        mst_req_o  = '0;

        slv_resp_o.aw_ready = (w_state == W_IDLE) && !rst_i;
        slv_resp_o.ar_ready = (r_state == R_IDLE) && !rst_i;

        mst_req_o.aw.id     = w_id;
        mst_req_o.aw.addr   = w_addr;
        mst_req_o.aw.size   = w_size;
        mst_req_o.aw.burst  = BURST_INCR;
        mst_req_o.aw.cache  = w_cache;
        mst_req_o.aw.prot   = w_prot;
        mst_req_o.aw.qos    = w_qos;
        mst_req_o.aw.region = w_region;
        mst_req_o.aw.user   = w_user;
        mst_req_o.aw_valid  = (w_state == W_ADDR);

        mst_req_o.w         = slv_req_i.w;
        mst_req_o.w.last    = 1'b1;
        mst_req_o.w_valid   = (w_state == W_DATA) && slv_req_i.w_valid;
        slv_resp_o.w_ready  = (w_state == W_DATA) ? mst_resp_i.w_ready : (w_state == W_DRAIN);
        mst_req_o.b_ready   = (w_state == W_RESP);

        slv_resp_o.b_valid  = (w_state == W_BRESP);
        slv_resp_o.b.id     = w_id;
        slv_resp_o.b.resp   = w_resp;
        slv_resp_o.b.user   = w_user;

        mst_req_o.ar.id     = r_id;
        mst_req_o.ar.addr   = r_addr;
        mst_req_o.ar.size   = r_size;
        mst_req_o.ar.burst  = BURST_INCR;
        mst_req_o.ar.cache  = r_cache;
        mst_req_o.ar.prot   = r_prot;
        mst_req_o.ar.qos    = r_qos;
        mst_req_o.ar.region = r_region;
        mst_req_o.ar.user   = r_user;
        mst_req_o.ar_valid  = (r_state == R_ADDR);

        slv_resp_o.r.id     = r_id;
        slv_resp_o.r.last   = (r_cnt == 8'd0);
        if (r_state == R_DATA) begin
            slv_resp_o.r_valid = mst_resp_i.r_valid;
            slv_resp_o.r.data  = mst_resp_i.r.data;
            slv_resp_o.r.resp  = mst_resp_i.r.resp;
            slv_resp_o.r.user  = mst_resp_i.r.user;
            mst_req_o.r_ready  = slv_req_i.r_ready;
        end else if (r_state == R_ERR) begin
            slv_resp_o.r_valid = 1'b1;
            slv_resp_o.r.resp  = RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter with a single-beat downstream slave model.
module tb_axi_burst_splitter;
    import axi_burst_splitter_pkg::*;

    localparam int TMO = 400;
    localparam logic [63:0] RK = 64'h5A5A_0000_0000_5A5A;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    axi_req_t  slv_req;
    axi_resp_t slv_resp;
    axi_req_t  mst_req;
    axi_resp_t mst_resp;

    aw_chan_t aw;
    ar_chan_t ar;
    w_chan_t  w;
    logic aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Downstream model state and logs.
    logic        dn_b_pend = 1'b0, dn_r_pend = 1'b0;
    logic [1:0]  dn_b_resp = 2'b00;
    logic [63:0] dn_r_data = '0;
    logic [63:0] dn_aw[$];
    logic [63:0] dn_ar[$];
    logic [63:0] dn_w[$];
    int          dn_bad = 0;
    int          wbeats = 0;
    int          err_abs = -1;
    logic [1:0]  err_code = 2'b00;

    logic [4:0]  rd_id[256];
    logic [63:0] rd_data[256];
    logic [1:0]  rd_resp[256];
    logic        rd_last[256];

    always #5 clk = ~clk;

    always_comb begin
        slv_req          = '0;
        slv_req.aw       = aw;
        slv_req.aw_valid = aw_valid;
        slv_req.w        = w;
        slv_req.w_valid  = w_valid;
        slv_req.b_ready  = b_ready;
        slv_req.ar       = ar;
        slv_req.ar_valid = ar_valid;
        slv_req.r_ready  = r_ready;
    end

    always_comb begin
        mst_resp          = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.b_valid  = dn_b_pend;
        mst_resp.b.resp   = dn_b_resp;
        mst_resp.r_valid  = dn_r_pend;
        mst_resp.r.data   = dn_r_data;
        mst_resp.r.resp   = RESP_OKAY;
        mst_resp.r.last   = 1'b1;
    end

    // Always-ready single-beat slave; B/R follow one cycle after W/AR.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_b_pend <= 1'b0;
            dn_r_pend <= 1'b0;
        end else begin
            if (mst_req.aw_valid) begin
                dn_aw.push_back(mst_req.aw.addr);
                if (mst_req.aw.len != 8'd0 || mst_req.aw.burst != BURST_INCR) dn_bad <= dn_bad + 1;
            end
            if (dn_b_pend && mst_req.b_ready) dn_b_pend <= 1'b0;
            if (mst_req.w_valid) begin
                dn_w.push_back(mst_req.w.data);
                if (!mst_req.w.last) dn_bad <= dn_bad + 1;
                dn_b_pend <= 1'b1;
                dn_b_resp <= (wbeats == err_abs) ? err_code : RESP_OKAY;
                wbeats    <= wbeats + 1;
            end
            if (dn_r_pend && mst_req.r_ready) dn_r_pend <= 1'b0;
            if (mst_req.ar_valid) begin
                dn_ar.push_back(mst_req.ar.addr);
                if (mst_req.ar.len != 8'd0) dn_bad <= dn_bad + 1;
                dn_r_pend <= 1'b1;
                dn_r_data <= mst_req.ar.addr ^ RK;
            end
        end
    end

    axi_burst_splitter #(
        .AXI_ID_WIDTH (5),
        .req_t        (axi_req_t),
        .resp_t       (axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wdata(input logic [4:0] id, input int i);
        return {16'hD00D, 11'd0, id, i[31:0]};
    endfunction

    task automatic do_write(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [5:0] atop, input bit bp,
                            output logic [4:0] bid, output logic [1:0] bresp, output bit ok);
        int t;
        ok = 1'b1;
        bid = '0;
        bresp = '0;
        @(negedge clk);
        aw = '0;
        aw.id = id; aw.addr = addr; aw.len = len; aw.size = size; aw.burst = burst;
        aw.atop = atop; aw.prot = 3'd2; aw.cache = 4'd3;
        aw_valid = 1'b1;
        t = 0;
        while (!slv_resp.aw_ready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin aw_valid = 1'b0; ok = 1'b0; return; end
        @(posedge clk); #1 aw_valid = 1'b0;
        chk("aw_dn_valid_latency", mst_req.aw_valid, (atop == 6'd0 && burst != BURST_RSVD));
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            w.data = wdata(id, i); w.strb = '1; w.last = (i == int'(len)); w.user = '0;
            w_valid = 1'b1;
            t = 0;
            while (!slv_resp.w_ready && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin w_valid = 1'b0; ok = 1'b0; return; end
            @(posedge clk); #1 w_valid = 1'b0;
        end
        t = 0;
        do begin
            @(negedge clk);
            b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            t++;
        end while (!(slv_resp.b_valid && b_ready) && t < TMO);
        if (!(slv_resp.b_valid && b_ready)) begin b_ready = 1'b0; ok = 1'b0; return; end
        bid = slv_resp.b.id;
        bresp = slv_resp.b.resp;
        @(posedge clk); #1 b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bp,
                           output int nbeats);
        int t, n, extra;
        nbeats = 0;
        @(negedge clk);
        ar = '0;
        ar.id = id; ar.addr = addr; ar.len = len; ar.size = size; ar.burst = burst;
        ar_valid = 1'b1;
        t = 0;
        while (!slv_resp.ar_ready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin ar_valid = 1'b0; return; end
        @(posedge clk); #1 ar_valid = 1'b0;
        chk("ar_dn_valid_latency", mst_req.ar_valid, (burst != BURST_RSVD));
        n = 0;
        t = 0;
        while (n <= int'(len) && t < 4 * TMO) begin
            @(negedge clk);
            r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (slv_resp.r_valid && r_ready) begin
                rd_id[n] = slv_resp.r.id; rd_data[n] = slv_resp.r.data;
                rd_resp[n] = slv_resp.r.resp; rd_last[n] = slv_resp.r.last;
                n++;
            end
            t++;
        end
        @(posedge clk); #1;
        // Extra beats after the burst would indicate duplication.
        extra = 0;
        r_ready = 1'b1;
        repeat (4) begin @(negedge clk); if (slv_resp.r_valid) extra++; end
        r_ready = 1'b0;
        nbeats = n + extra;
    endtask

    typedef struct packed {
        bit              wr;
        logic [4:0]      id;
        logic [63:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [5:0]      atop;
        int              err_beat;
        logic [1:0]      err_code;
        int              n_dn;
        logic [3:0][63:0] ea;
        logic [1:0]      exp_resp;
    } vec_t;

    function automatic vec_t mkv(bit wr, logic [4:0] id, logic [63:0] addr, logic [7:0] len,
                                 logic [2:0] size, logic [1:0] burst, logic [5:0] atop,
                                 int eb, logic [1:0] ec, int n, logic [63:0] a0, logic [63:0] a1,
                                 logic [63:0] a2, logic [63:0] a3, logic [1:0] er);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.atop = atop; v.err_beat = eb; v.err_code = ec; v.n_dn = n;
        v.ea = {a3, a2, a1, a0}; v.exp_resp = er;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vecs[NV];
    logic [4:0] bid;
    logic [1:0] bresp;
    bit   ok, cw_ok;
    int   nb, n0, w0, c_nb;
    logic [4:0] c_bid;
    logic [1:0] c_bresp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        aw = '0; ar = '0; w = '0;
        vecs[0]  = mkv(1, 5'h0A, 64'h0200_4000, 3, 3, BURST_INCR, 0, -1, 0, 4,
                       64'h0200_4000, 64'h0200_4008, 64'h0200_4010, 64'h0200_4018, RESP_OKAY);
        vecs[1]  = mkv(0, 5'h11, 64'h0200_BFF8, 3, 3, BURST_WRAP, 0, -1, 0, 4,
                       64'h0200_BFF8, 64'h0200_BFE0, 64'h0200_BFE8, 64'h0200_BFF0, RESP_OKAY);
        vecs[2]  = mkv(1, 5'h02, 64'h0200_4000, 3, 3, BURST_INCR, 0, 1, RESP_SLVERR, 4,
                       64'h0200_4000, 64'h0200_4008, 64'h0200_4010, 64'h0200_4018, RESP_SLVERR);
        vecs[3]  = mkv(1, 5'h04, 64'h0200_0000, 1, 3, BURST_INCR, 6'h20, -1, 0, 0,
                       0, 0, 0, 0, RESP_SLVERR);
        vecs[4]  = mkv(0, 5'h05, 64'h0200_0100, 1, 3, BURST_RSVD, 0, -1, 0, 0,
                       0, 0, 0, 0, RESP_SLVERR);
        vecs[5]  = mkv(1, 5'h06, 64'h1000, 2, 2, BURST_FIXED, 0, -1, 0, 3,
                       64'h1000, 64'h1000, 64'h1000, 0, RESP_OKAY);
        vecs[6]  = mkv(0, 5'h07, 64'h2000_0008, 0, 3, BURST_INCR, 0, -1, 0, 1,
                       64'h2000_0008, 0, 0, 0, RESP_OKAY);
        vecs[7]  = mkv(1, 5'h08, 64'h10C, 2, 2, BURST_WRAP, 0, -1, 0, 3,
                       64'h10C, 64'h110, 64'h114, 0, RESP_OKAY);
        vecs[8]  = mkv(1, 5'h09, 64'h104, 1, 2, BURST_WRAP, 0, -1, 0, 2,
                       64'h104, 64'h100, 0, 0, RESP_OKAY);
        vecs[9]  = mkv(0, 5'h0B, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3, BURST_INCR, 0, -1, 0, 2,
                       64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, RESP_OKAY);
        vecs[10] = mkv(1, 5'h0C, 64'h2000, 1, 3, BURST_INCR, 0, 0, RESP_DECERR, 2,
                       64'h2000, 64'h2008, 0, 0, RESP_DECERR);
        vecs[11] = mkv(1, 5'h0D, 64'h3000, 1, 3, BURST_INCR, 0, 1, RESP_EXOKAY, 2,
                       64'h3000, 64'h3008, 0, 0, RESP_OKAY);
        vecs[12] = mkv(1, 5'h0E, 64'h4000, 0, 3, BURST_RSVD, 0, -1, 0, 0,
                       0, 0, 0, 0, RESP_SLVERR);
        vecs[13] = mkv(0, 5'h0F, 64'h30, 1, 4, BURST_WRAP, 0, -1, 0, 2,
                       64'h30, 64'h20, 0, 0, RESP_OKAY);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", slv_resp.aw_ready, 0);
        chk("rst_ar_ready", slv_resp.ar_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_aw_ready", slv_resp.aw_ready, 1);
        chk("post_rst_ar_ready", slv_resp.ar_ready, 1);
        chk("post_rst_w_ready", slv_resp.w_ready, 0);
        chk("post_rst_b_valid", slv_resp.b_valid, 0);
        chk("post_rst_r_valid", slv_resp.r_valid, 0);
        chk("post_rst_dn_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid}, 0);
        chk("post_rst_dn_readies", {mst_req.b_ready, mst_req.r_ready}, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                n0 = dn_aw.size();
                w0 = dn_w.size();
                err_abs  = (vecs[i].err_beat >= 0) ? wbeats + vecs[i].err_beat : -1;
                err_code = vecs[i].err_code;
                do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                         vecs[i].atop, 1'b0, bid, bresp, ok);
                chk($sformatf("v%0d_done", i), ok, 1);
                chk($sformatf("v%0d_bid", i), bid, vecs[i].id);
                chk($sformatf("v%0d_bresp", i), bresp, vecs[i].exp_resp);
                chk($sformatf("v%0d_dn_aw_cnt", i), dn_aw.size() - n0, vecs[i].n_dn);
                chk($sformatf("v%0d_dn_w_cnt", i), dn_w.size() - w0, vecs[i].n_dn);
                for (int j = 0; j < vecs[i].n_dn && n0 + j < dn_aw.size(); j++)
                    chk($sformatf("v%0d_aw%0d", i, j), dn_aw[n0 + j], vecs[i].ea[j]);
                for (int j = 0; j < vecs[i].n_dn && w0 + j < dn_w.size(); j++)
                    chk($sformatf("v%0d_w%0d", i, j), dn_w[w0 + j], wdata(vecs[i].id, j));
            end else begin
                n0 = dn_ar.size();
                do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                        1'b0, nb);
                chk($sformatf("v%0d_beats", i), nb, int'(vecs[i].len) + 1);
                chk($sformatf("v%0d_dn_ar_cnt", i), dn_ar.size() - n0, vecs[i].n_dn);
                for (int j = 0; j < vecs[i].n_dn && n0 + j < dn_ar.size(); j++)
                    chk($sformatf("v%0d_ar%0d", i, j), dn_ar[n0 + j], vecs[i].ea[j]);
                for (int j = 0; j <= int'(vecs[i].len) && j < nb; j++) begin
                    chk($sformatf("v%0d_rid%0d", i, j), rd_id[j], vecs[i].id);
                    chk($sformatf("v%0d_rlast%0d", i, j), rd_last[j], (j == int'(vecs[i].len)));
                    chk($sformatf("v%0d_rresp%0d", i, j), rd_resp[j], vecs[i].exp_resp);
                    chk($sformatf("v%0d_rdata%0d", i, j), rd_data[j],
                        (vecs[i].burst == BURST_RSVD) ? 64'h0 : (vecs[i].ea[j] ^ RK));
                end
            end
        end
        err_abs = -1;

        // Concurrent write and read with random upstream backpressure
        n0 = dn_aw.size();
        w0 = dn_w.size();
        fork
            do_write(5'h15, 64'h3000, 3, 3, BURST_INCR, 0, 1'b1, c_bid, c_bresp, cw_ok);
            do_read(5'h16, 64'h5000, 3, 3, BURST_INCR, 1'b1, c_nb);
        join
        chk("conc_w_done", cw_ok, 1);
        chk("conc_bid", c_bid, 5'h15);
        chk("conc_bresp", c_bresp, RESP_OKAY);
        chk("conc_dn_aw_cnt", dn_aw.size() - n0, 4);
        for (int j = 0; j < 4 && w0 + j < dn_w.size(); j++)
            chk($sformatf("conc_w%0d", j), dn_w[w0 + j], wdata(5'h15, j));
        chk("conc_r_beats", c_nb, 4);
        for (int j = 0; j < 4 && j < c_nb; j++) begin
            chk($sformatf("conc_rid%0d", j), rd_id[j], 5'h16);
            chk($sformatf("conc_rdata%0d", j), rd_data[j], (64'h5000 + 64'(8 * j)) ^ RK);
            chk($sformatf("conc_rlast%0d", j), rd_last[j], (j == 3));
        end

        // Longest INCR burst: 256 single beats, no counter underflow
        n0 = dn_aw.size();
        do_write(5'h01, 64'h8000, 8'd255, 3, BURST_INCR, 0, 1'b0, bid, bresp, ok);
        chk("len255_done", ok, 1);
        chk("len255_bresp", bresp, RESP_OKAY);
        chk("len255_dn_aw_cnt", dn_aw.size() - n0, 256);
        if (dn_aw.size() - n0 == 256) begin
            chk("len255_first", dn_aw[n0], 64'h8000);
            chk("len255_last", dn_aw[n0 + 255], 64'h87F8);
        end

        // Reset during beat 2 of a 4-beat write
        n0 = dn_aw.size();
        @(negedge clk);
        aw = '0; aw.id = 5'h03; aw.addr = 64'h6000; aw.len = 3; aw.size = 3; aw.burst = BURST_INCR;
        aw_valid = 1'b1;
        @(posedge clk); #1 aw_valid = 1'b0;
        @(negedge clk);
        w.data = wdata(5'h03, 0); w.last = 1'b0; w_valid = 1'b1;
        begin
            int t;
            t = 0;
            while (!slv_resp.w_ready && t < TMO) begin @(negedge clk); t++; end
            @(posedge clk); #1 w_valid = 1'b0;
            t = 0;
            while (dn_aw.size() < n0 + 2 && t < TMO) begin @(negedge clk); t++; end
        end
        chk("midrst_reached_beat2", dn_aw.size() - n0, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_aw_ready_low", slv_resp.aw_ready, 0);
        @(posedge clk); #1;
        chk("midrst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                              slv_resp.b_valid, slv_resp.r_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_aw_ready", slv_resp.aw_ready, 1);
        n0 = dn_aw.size();
        do_write(5'h07, 64'h7000, 0, 3, BURST_INCR, 0, 1'b0, bid, bresp, ok);
        chk("after_rst_done", ok, 1);
        chk("after_rst_bid", bid, 5'h07);
        chk("after_rst_bresp", bresp, RESP_OKAY);
        chk("after_rst_dn_aw_cnt", dn_aw.size() - n0, 1);
        if (dn_aw.size() - n0 == 1) chk("after_rst_addr", dn_aw[n0], 64'h7000);

        chk("dn_single_beat_violations", dn_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
